// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and the total-span
// derivation used by the timing generator and the pixel generators.
//   coord_t       : 10-bit pixel/line coordinate type
//   span_total()  : display + front porch + sync + back porch
package vga_timing_pkg;

  localparam int unsigned COORD_W       = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned ANIM_DIV_DEF  = 16;

  function automatic int unsigned span_total(input int unsigned disp,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return disp + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL_DEF = span_total(H_DISPLAY_DEF, H_FRONT_DEF,
                                                   H_SYNC_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL_DEF = span_total(V_DISPLAY_DEF, V_FRONT_DEF,
                                                   V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/anim_divider.sv
// Animation divider: counts frame ticks and toggles the animation phase bit
// once every ANIM_DIV ticks. Pause holds both the counter and the phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-cycle strobe on the edge entering vertical blanking
//   pause      : high holds counter and phase
//   frame      : animation phase bit
module anim_divider #(
  parameter int unsigned ANIM_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pause,
  output logic frame
);

  localparam int unsigned CNT_W = $clog2(ANIM_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_q, frame_d;

  // ANIM_DIV is a power of two, so the counter wraps naturally and the
  // phase flips on the same edge the counter returns to zero.
  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (tick && !pause) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) frame_d = ~frame_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/vga_anim_timing.sv
// VGA timing generator with an animation phase output.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   ena          : count enable; low freezes all state
//   anim_pause   : freezes the animation phase only
//   hsync, vsync : active-low syncs decoded from the live counters
//   display_on   : high inside the visible area
//   pix_x, pix_y : current position, straight from the counter registers
//   frame        : animation phase bit
//   frame_start  : one-cycle pulse at (0, V_DISPLAY)
module vga_anim_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter int unsigned ANIM_DIV  = ANIM_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       anim_pause,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   frame_start_q, frame_start_d;

  // frame_start_d is decoded from the next-state counters so the registered
  // pulse lines up with the cycle in which the counters read (0, V_DISPLAY);
  // the same strobe clocks the animation divider.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (ena) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      frame_start_d = (x_d == '0) && (y_d == V_VIS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  anim_divider #(
    .ANIM_DIV(ANIM_DIV)
  ) u_anim (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (frame_start_d),
    .pause(anim_pause),
    .frame(frame)
  );

  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = frame_start_q;
  assign hsync       = !((x_q >= HS_START) && (x_q < HS_END));
  assign vsync       = !((y_q >= VS_START) && (y_q < VS_END));
  assign display_on  = (x_q < H_VIS) && (y_q < V_VIS);

endmodule

// File: tb/tb_vga_anim_timing.sv
// Testbench for vga_anim_timing. Uses a reduced geometry (34 x 19 total,
// 20 x 12 visible) and ANIM_DIV=4 so many frames fit in a short run; all
// expectations scale from the localparams below.
module tb_vga_anim_timing;

  localparam int HD = 20, HF = 4, HS = 6, HB = 4;
  localparam int VD = 12, VF = 2, VS = 2, VB = 3;
  localparam int DIV = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n, ena, anim_pause;
  logic       hsync, vsync, display_on, frame, frame_start;
  logic [9:0] pix_x, pix_y;

  vga_anim_timing #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ANIM_DIV(DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .anim_pause (anim_pause),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame      (frame),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; bit hs; bit vs; bit de; bit fs; bit fr; int cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_err = 0;

  int   mx = 0, my = 0, mcnt = 0;
  bit   mfr = 1'b0;

  int   hs_low, hs_first_x, vs_low, de_cnt, fs_cnt, tog_cnt;
  int   tog_at[$];
  bit   prev_fr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model_step(input bit e, input bit p);
    exp_t r;
    bit   fs;
    fs = 1'b0;
    if (e) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      fs = (mx == 0) && (my == VD);
      if (fs && !p) begin
        if (mcnt == DIV - 1) begin
          mcnt = 0;
          mfr  = !mfr;
        end else begin
          mcnt = mcnt + 1;
        end
      end
    end
    r.x   = mx;
    r.y   = my;
    r.hs  = !(mx >= HD + HF && mx < HD + HF + HS);
    r.vs  = !(my >= VD + VF && my < VD + VF + VS);
    r.de  = (mx < HD) && (my < VD);
    r.fs  = fs;
    r.fr  = mfr;
    r.cnt = mcnt;
    return r;
  endfunction

  task automatic clear_stats();
    hs_low = 0; hs_first_x = -1; vs_low = 0; de_cnt = 0;
    fs_cnt = 0; tog_cnt = 0; tog_at.delete();
  endtask

  // Entered just after a falling edge; returns on the next falling edge.
  task automatic cycle(input bit e, input bit p);
    exp_t x;
    ena        = e;
    anim_pause = p;
    q.push_back(model_step(e, p));
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      x = q.pop_front();
      chk("pix_x",       32'(pix_x),       32'(x.x));
      chk("pix_y",       32'(pix_y),       32'(x.y));
      chk("hsync",       32'(hsync),       32'(x.hs));
      chk("vsync",       32'(vsync),       32'(x.vs));
      chk("display_on",  32'(display_on),  32'(x.de));
      chk("frame_start", 32'(frame_start), 32'(x.fs));
      chk("frame",       32'(frame),       32'(x.fr));
      chk("frame_cnt",   32'(dut.u_anim.cnt_q), 32'(x.cnt));
    end
    if (!hsync) begin
      if (hs_low == 0) hs_first_x = int'(pix_x);
      hs_low++;
    end
    if (!vsync) vs_low++;
    if (display_on) de_cnt++;
    if (frame_start) fs_cnt++;
    if (frame !== prev_fr) begin
      tog_cnt++;
      tog_at.push_back(fs_cnt);
      chk("toggle_in_blank", 32'(display_on), 32'd0);
      chk("toggle_on_fs",    32'(frame_start), 32'd1);
    end
    prev_fr = frame;
    @(negedge clk);
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mcnt = 0; mfr = 1'b0; prev_fr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},   32'(pix_x),       32'd0);
    chk({tag, "_y"},   32'(pix_y),       32'd0);
    chk({tag, "_hs"},  32'(hsync),       32'd1);
    chk({tag, "_vs"},  32'(vsync),       32'd1);
    chk({tag, "_de"},  32'(display_on),  32'd1);
    chk({tag, "_fr"},  32'(frame),       32'd0);
    chk({tag, "_fs"},  32'(frame_start), 32'd0);
    chk({tag, "_cnt"}, 32'(dut.u_anim.cnt_q), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    bit fr0;
    int cnt0;
    rst_n = 1'b0; ena = 1'b0; anim_pause = 1'b0;
    @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;

    // One line: first edge goes to (1,0), y steps at the wrap.
    clear_stats();
    repeat (HT) cycle(1'b1, 1'b0);
    chk("line_y_step",   32'(pix_y), 32'd1);
    chk("hs_low_len",    32'(hs_low), 32'(HS));
    chk("hs_first_x",    32'(hs_first_x), 32'(HD + HF));

    // One full frame window.
    clear_stats();
    repeat (FRAME) cycle(1'b1, 1'b0);
    chk("vs_low_len",    32'(vs_low), 32'(VS * HT));
    chk("de_count",      32'(de_cnt), 32'(HD * VD));
    chk("fs_per_frame",  32'(fs_cnt), 32'd1);

    // Animation divider over nine frames from reset.
    do_reset();
    clear_stats();
    repeat (9 * FRAME) cycle(1'b1, 1'b0);
    chk("anim_fs_count", 32'(fs_cnt), 32'd9);
    chk("anim_toggles",  32'(tog_cnt), 32'd2);
    if (tog_at.size() >= 2) begin
      chk("anim_tog1_at", 32'(tog_at[0]), 32'd4);
      chk("anim_tog2_at", 32'(tog_at[1]), 32'd8);
    end

    // Pause across eight frames.
    fr0  = mfr;
    cnt0 = mcnt;
    clear_stats();
    repeat (8 * FRAME) cycle(1'b1, 1'b1);
    chk("pause_fs_count", 32'(fs_cnt), 32'd8);
    chk("pause_frame",    32'(frame), 32'(fr0));
    chk("pause_cnt",      32'(dut.u_anim.cnt_q), 32'(cnt0));
    chk("pause_toggles",  32'(tog_cnt), 32'd0);

    // Unpause: counter resumes from 1 and wraps on the third tick.
    repeat (3 * FRAME) cycle(1'b1, 1'b0);
    chk("resume_frame", 32'(frame), 32'd1);

    // Freeze at the last pixel before vertical blanking.
    for (int i = 0; i < FRAME && !(mx == HT - 1 && my == VD - 1); i++)
      cycle(1'b1, 1'b0);
    chk("freeze_at_x", 32'(pix_x), 32'(HT - 1));
    chk("freeze_at_y", 32'(pix_y), 32'(VD - 1));
    clear_stats();
    repeat (100) cycle(1'b0, 1'b0);
    chk("freeze_no_fs", 32'(fs_cnt), 32'd0);
    cycle(1'b1, 1'b0);
    chk("thaw_x",  32'(pix_x), 32'd0);
    chk("thaw_y",  32'(pix_y), 32'(VD));
    chk("thaw_fs", 32'(frame_start), 32'd1);

    // Asynchronous reset mid-line while frame=1.
    for (int i = 0; i < FRAME && !(mx == 10 && my == 7); i++)
      cycle(1'b1, 1'b0);
    chk("pre_async_frame", 32'(frame), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    @(posedge clk);
    #1 chk("async_hold_x", 32'(pix_x), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
